decode_stage: RTL

Registered RISC-V decode stage that generalises plain field breakdown. It splits a 32-bit instruction into opcode, funct and register fields, classifies its format, and produces one sign-extended immediate of parametrised width XLEN (RV32/RV64). It also flags illegal encodings. It sits between fetch and register-read, with a valid/ready handshake on both sides, a two-entry skid buffer for full throughput under backpressure, and a pipeline flush.

---
 rtl/decode_stage_if.sv | 41 ++++
 rtl/decode_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// decode_stage_if
//   Bundles the fetch-side and register-read-side handshakes of the decode
//   stage together with the decoded payload.
//   Upstream:   in_valid, in_ready, in_instr[31:0], in_pc[XLEN-1:0]
//   Downstream: out_valid, out_ready, out_pc, out_opcode, out_funct3,
//               out_funct7, out_rs1, out_rs2, out_rd, out_imm, out_fmt,
//               out_illegal
//   Modports: slave  = the decode stage itself
//             master = the surrounding pipeline (fetch + register read)
interface decode_stage_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, out_imm, out_fmt, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rs1, out_rs2, out_rd, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage
//   Registered RISC-V decode stage. Splits the raw instruction into fields,
//   classifies its format (0=R 1=I 2=S 3=B 4=U 5=J), builds the sign-extended
//   immediate and flags illegal encodings. An output register plus a skid
//   register give full throughput under backpressure without any
//   combinational path from out_ready to in_ready.
//   Ports: clk   - rising-edge clock
//          rst_n - asynchronous active-low reset
//          flush - drop every held instruction at the next edge
//          bus   - decode_stage_if.slave (upstream/downstream handshakes)
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  decode_stage_if.slave  bus
);
  localparam bit IS_RV64 = (XLEN == 64);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  // ---------------- combinational decode of in_instr ----------------
  logic [31:0]     instr;
  logic [2:0]      fmt_raw;
  logic            legal;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  entry_t          dec;

  assign instr = bus.in_instr;

  always_comb begin
    fmt_raw = FMT_R;
    legal   = 1'b1;
    case (instr[6:0])
      7'b0110011: fmt_raw = FMT_R;
      7'b0111011: begin fmt_raw = FMT_R; legal = IS_RV64; end
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111: fmt_raw = FMT_I;
      7'b0011011: begin fmt_raw = FMT_I; legal = IS_RV64; end
      7'b0100011: fmt_raw = FMT_S;
      7'b1100011: fmt_raw = FMT_B;
      7'b0110111, 7'b0010111: fmt_raw = FMT_U;
      7'b1101111: fmt_raw = FMT_J;
      default:    legal = 1'b0;
    endcase
    // Compressed-space encodings are never accepted, whatever the opcode.
    if (instr[1:0] != 2'b11) legal = 1'b0;
  end

  always_comb begin
    imm32 = 32'd0;
    case (fmt_raw)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  // Every immediate is already sign-correct at 32 bits; widen for RV64.
  if (XLEN == 64) begin : g_ext64
    assign imm_ext = {{32{imm32[31]}}, imm32};
  end else begin : g_ext32
    assign imm_ext = imm32;
  end

  always_comb begin
    dec.pc      = bus.in_pc;
    dec.instr   = instr;
    dec.illegal = !legal;
    dec.fmt     = legal ? fmt_raw : FMT_R;
    dec.imm     = legal ? imm_ext : '0;
  end

  // ---------------- output + skid buffering ----------------
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   accept;

  assign bus.in_ready = !skid_valid_q && !flush;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || bus.out_ready) begin
      // Output slot is free this edge; the skid entry is older than any
      // new arrival (and accept is impossible while skid is occupied).
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_opcode  = out_q.instr[6:0];
  assign bus.out_funct3  = out_q.instr[14:12];
  assign bus.out_funct7  = out_q.instr[31:25];
  assign bus.out_rs1     = out_q.instr[19:15];
  assign bus.out_rs2     = out_q.instr[24:20];
  assign bus.out_rd      = out_q.instr[11:7];
  assign bus.out_imm     = out_q.imm;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = out_q.illegal;
endmodule
